// File: rtl/serial_adder_seq_if.sv
// Bundles the operand/result handshake and the external full-adder cell connection
// of the bit-serial adder into one port.
interface serial_adder_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             fa_a;
    logic             fa_b;
    logic             fa_cin;
    logic             fa_s;
    logic             fa_cout;

    modport slave (
        input  start, a, b, cin, fa_s, fa_cout,
        output busy, done, sum, cout, fa_a, fa_b, fa_cin
    );

    modport master (
        output start, a, b, cin, fa_s, fa_cout,
        input  busy, done, sum, cout, fa_a, fa_b, fa_cin
    );
endinterface

// File: rtl/serial_adder_seq.sv
// Bit-serial adder: one external full-adder cell walks WIDTH bits LSB first.
// done pulses in the cycle after edge WIDTH past start; no backpressure, start ignored unless idle.
module serial_adder_seq #(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               rst,
    serial_adder_seq_if.slave io
);
    // One extra count bit so the increment on the final RUN edge cannot wrap.
    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ar_q, ar_d;
    logic [WIDTH-1:0] br_q, br_d;
    logic             cr_q, cr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ar_q    <= '0;
            br_q    <= '0;
            cr_q    <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ar_q    <= ar_d;
            br_q    <= br_d;
            cr_q    <= cr_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ar_d    = ar_q;
        br_d    = br_q;
        cr_d    = cr_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        unique case (state_q)
            IDLE: begin
                if (io.start) begin
                    ar_d    = io.a;
                    br_d    = io.b;
                    cr_d    = io.cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Result bits enter at the MSB so after WIDTH shifts bit 0 lands at the LSB.
                sum_d = {io.fa_s, sum_q[WIDTH-1:1]};
                ar_d  = {1'b0, ar_q[WIDTH-1:1]};
                br_d  = {1'b0, br_q[WIDTH-1:1]};
                cr_d  = io.fa_cout;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cout_d  = io.fa_cout;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign run       = (state_q == RUN);
    assign io.busy   = run;
    assign io.done   = (state_q == DONE);
    assign io.sum    = sum_q;
    assign io.cout   = cout_q;
    assign io.fa_a   = run & ar_q[0];
    assign io.fa_b   = run & br_q[0];
    assign io.fa_cin = run & cr_q;
endmodule
